// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, instruction
// field positions, FSM state and retire-class encodings.
package alu_issue_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int RADR_W = 3;
  localparam int RES_W  = 17;
  localparam int IMM_W  = 9;

  localparam logic [3:0] OP_DIV  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHR1 = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_INC  = 4'd10;
  localparam logic [3:0] OP_DEC  = 4'd11;
  localparam logic [3:0] OP_LDI  = 4'd12;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 8;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    K_ALU  = 2'd0,
    K_LDI  = 2'd1,
    K_ILL  = 2'd2,
    K_DIV0 = 2'd3
  } kind_t;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op > OP_LDI);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x16 register file: one write port, two registered read ports that double
// as the ALU operand registers; everything clears on async reset.
module alu_regfile
  import alu_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rd_en,
  input  logic [RADR_W-1:0] i_rs1,
  input  logic [RADR_W-1:0] i_rs2,
  input  logic              i_we,
  input  logic [RADR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] r_rf [NREGS];
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;

  // storage array with single write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (i_we) begin
      r_rf[i_waddr] <= i_wdata;
    end
  end

  // registered read ports, loaded only when an instruction is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata1 <= '0;
      r_rdata2 <= '0;
    end else if (i_rd_en) begin
      r_rdata1 <= r_rf[i_rs1];
      r_rdata2 <= r_rf[i_rs2];
    end
  end

  assign o_rdata1 = r_rdata1;
  assign o_rdata2 = r_rdata2;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/retire sequencer in front of the external combinational ALU:
// accept -> EXEC (ALU settles, write back) -> DONE (status pulse) -> IDLE.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_control,
  input  logic [RES_W-1:0]  alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_parity,
  output logic              done,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_p,
  output logic              err_illegal,
  output logic              err_div0
);

  state_t             r_state;
  logic               r_ready;
  logic [3:0]         r_op;
  logic [RADR_W-1:0]  r_rd;
  logic [IMM_W-1:0]   r_imm;
  logic               r_done;
  logic [DATA_W-1:0]  r_wb;
  logic               r_fz, r_fc, r_fp;
  logic               r_ill, r_div0;

  logic               w_accept;
  kind_t              w_kind;
  logic               w_we;
  logic [DATA_W-1:0]  w_wdata;
  logic               w_unused_res_msb;

  // carry arrives separately as alu_carry
  assign w_unused_res_msb = alu_result[RES_W-1];
  assign w_accept = (r_state == ST_IDLE) && r_ready && instr_valid;

  alu_regfile u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_rd_en  (w_accept),
    .i_rs1    (instr[RS1_MSB:RS1_LSB]),
    .i_rs2    (instr[RS2_MSB:RS2_LSB]),
    .i_we     (w_we),
    .i_waddr  (r_rd),
    .i_wdata  (w_wdata),
    .o_rdata1 (alu_a),
    .o_rdata2 (alu_b)
  );

  // classify the instruction in flight and form the write-back request
  always_comb begin
    w_kind  = K_ALU;
    w_wdata = alu_result[DATA_W-1:0];
    case (r_op)
      OP_LDI: begin
        w_kind  = K_LDI;
        w_wdata = {7'd0, r_imm};
      end
      OP_DIV: begin
        if (alu_b == '0) w_kind = K_DIV0;
        else             w_kind = K_ALU;
      end
      default: begin
        if (is_illegal(r_op)) w_kind = K_ILL;
        else                  w_kind = K_ALU;
      end
    endcase
    if (r_state == ST_EXEC) w_we = (w_kind == K_ALU) || (w_kind == K_LDI);
    else                    w_we = 1'b0;
  end

  // sequencing FSM with registered handshake, status and flag outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_op    <= 4'd0;
      r_rd    <= '0;
      r_imm   <= '0;
      r_done  <= 1'b0;
      r_wb    <= '0;
      r_fz    <= 1'b0;
      r_fc    <= 1'b0;
      r_fp    <= 1'b0;
      r_ill   <= 1'b0;
      r_div0  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_op    <= instr[OP_MSB:OP_LSB];
            r_rd    <= instr[RD_MSB:RD_LSB];
            r_imm   <= instr[IMM_MSB:IMM_LSB];
            r_wb    <= '0;
            r_ill   <= 1'b0;
            r_div0  <= 1'b0;
            r_ready <= 1'b0;
            r_state <= ST_EXEC;
          end else begin
            r_ready <= 1'b1;
          end
        end
        ST_EXEC: begin
          case (w_kind)
            K_LDI:  r_wb   <= w_wdata;
            K_ILL:  r_ill  <= 1'b1;
            K_DIV0: r_div0 <= 1'b1;
            default: begin
              r_wb <= w_wdata;
              r_fz <= alu_zero;
              r_fc <= alu_carry;
              r_fp <= alu_parity;
            end
          endcase
          r_done  <= 1'b1;
          r_ready <= 1'b0;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = r_ready;
  assign alu_control = r_op;
  assign done        = r_done;
  assign wb_data     = r_wb;
  assign flag_z      = r_fz;
  assign flag_c      = r_fc;
  assign flag_p      = r_fp;
  assign err_illegal = r_ill;
  assign err_div0    = r_div0;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequencing front-end that drives the datapath ALU. It accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 8-entry register file. It issues opcode, a and b to the ALU, then captures the 17-bit result and the flags. It writes results back to the register file and reports per-instruction status. It sits between the instruction source and the combinational ALU; the ALU itself stays outside this block.

Parameters:
DATA_W, 16, operand and register width; fixed at 16 in this revision.
NREGS, 8, register-file depth; the 3-bit register address fields require 8.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr  in  16  [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2; for LDI, [8:0] is imm9
instr_ready  out  1  block can accept an instruction
alu_a  out  16  ALU operand a (registered)
alu_b  out  16  ALU operand b (registered)
alu_control  out  4  ALU opcode (registered)
alu_result  in  17  ALU result (combinational from alu_* outputs)
alu_zero  in  1  ALU zero flag
alu_carry  in  1  ALU carry flag (result bit 16)
alu_parity  in  1  ALU parity flag
done  out  1  one-cycle pulse; instruction retired
wb_data  out  16  value written to rd; valid with done
flag_z  out  1  architectural zero flag
flag_c  out  1  architectural carry flag
flag_p  out  1  architectural parity flag
err_illegal  out  1  retired instruction had an illegal opcode; valid with done
err_div0  out  1  retired instruction was DIV with b==0; valid with done

Behaviour:
- Reset (async, rst_n=0): state IDLE; all register-file entries 0; every output 0 except instr_ready=1 once in IDLE after reset release. Reset mid-instruction aborts it: no register write, no flag update, no done.
- Opcodes 0000-1011 pass through to alu_control unchanged (DIV, ADD, SUB, MUL, AND, OR, XOR, NOT, SHR1, SHL, INC, DEC).
- Opcode 1100 = LDI: rd <= {7'b0, imm9}. The ALU is not used and flags are unchanged.
- Opcodes 1101-1111 are illegal.
- FSM:
  - IDLE: instr_ready=1. On instr_valid && instr_ready, latch instr; load alu_a<=rf[rs1], alu_b<=rf[rs2], alu_control<=op; go to EXEC.
  - EXEC: instr_ready=0. The ALU settles combinationally. At the closing edge:
    - Normal op: rf[rd]<=alu_result[15:0]; wb_data<=alu_result[15:0]; flag_z/c/p <= alu_zero/carry/parity.
    - LDI: write imm, wb_data<=imm.
    - Illegal op: no write; err_illegal<=1.
    - DIV with alu_b==0: no write, flags unchanged, err_div0<=1.
    - Go to DONE.
  - DONE: done=1 for exactly one cycle; wb_data and err_* hold. Go to IDLE. err_* and wb_data clear to 0 on the next accept.
- Latency: accept edge to done = 2 cycles. Throughput is 1 instruction per 3 cycles. instr_valid outside IDLE is ignored; the source must hold it until accepted.
- RAW hazard: the write completes at the end of EXEC, before the next accept, so back-to-back dependent instructions read the updated value. No forwarding is needed.
- rd==rs1 or rd==rs2 is legal: operands are latched before the write.
- Flags take the ALU flags over all 17 result bits. The stored result is truncated to 16 bits; for MUL the product is truncated to 17 bits by the ALU.

Decomposition:
- Shared package holds:
  - opcode localparams OP_DIV..OP_DEC, OP_LDI=4'b1100;
  - instruction field bit positions;
  - FSM state encoding (IDLE, EXEC, DONE).
- One sub-module is natural: alu_regfile (8x16, one write port, two registered read ports, async clear). The FSM and status logic stay in alu_issue_ctrl.
- The bench instantiates the existing ALU to close the loop.

Test Plan:
1. LDI r1,5; LDI r2,3; ADD r3,r1,r2 -> wb_data=0x0008, flag_z=0, flag_c=0, flag_p=1; done arrives 2 cycles after each accept.
2. SUB r4,r2,r1 (3-5) -> alu_result=0x1FFFE, wb_data=0xFFFE, flag_c=1, flag_p=0, flag_z=0.
3. DIV r5,r1,r0 (r0=0) -> done with err_div0=1; r5 still 0; flags still hold the values from scenario 2.
4. instr=0xE000 (illegal) -> done with err_illegal=1; no register or flag change. instr_valid held high through EXEC/DONE is not re-accepted.
5. Back-to-back ADD r1,r1,r1 twice with r1=5 -> wb_data 0x000A, then 0x0014. Accepts are exactly 3 cycles apart.
6. ADD issued, then rst_n pulsed low mid-EXEC -> rd not written; done, flags and rf all 0. instr_ready=1 the cycle after release.
